// File: rtl/johnson_code_monitor_pkg.sv
// Shared definitions for the Johnson code monitor and its decoder.
//   - johnson_is_legal(word, n): 1 when the low n bits form a Johnson
//     (thermometer) word, either 0..01..1 or 1..10..0.
//   - johnson_to_index(word, n): state index 0..2n-1 of a legal word.
//   - IDX_W: index width for the default word width.
//   - jcm_state_e: monitor FSM states.
package johnson_code_monitor_pkg;

  localparam int N_DEF = 4;
  localparam int IDX_W = $clog2(2 * N_DEF);
  // Functions work on a fixed-width container so any N up to MAX_W fits.
  localparam int MAX_W = 32;
  localparam logic [MAX_W-1:0] ONE_W = 1;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } jcm_state_e;

  function automatic logic [MAX_W-1:0] width_mask(input int n);
    if (n >= MAX_W) return '1;
    return (ONE_W << n) - ONE_W;
  endfunction

  // A word of the form 0..01..1 satisfies w & (w+1) == 0; the other
  // half of the sequence (1..10..0) is the same test on the inverse.
  function automatic logic johnson_is_legal(input logic [MAX_W-1:0] word,
                                            input int n);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] w;
    logic [MAX_W-1:0] inv;
    mask = width_mask(n);
    w    = word & mask;
    inv  = ~word & mask;
    return ((w & (w + ONE_W)) == '0) || ((inv & (inv + ONE_W)) == '0);
  endfunction

  // index = popcount when the MSB is clear, 2n - popcount otherwise.
  function automatic int johnson_to_index(input logic [MAX_W-1:0] word,
                                          input int n);
    logic [MAX_W-1:0] sh;
    int p;
    p = 0;
    for (int i = 0; i < MAX_W; i++) begin
      sh = word >> i;
      if (i < n && sh[0]) p++;
    end
    sh = word >> (n - 1);
    if (sh[0]) return 2 * n - p;
    return p;
  endfunction

endpackage

// File: rtl/johnson_code_monitor_if.sv
// Bus between a Johnson-phase source and the code monitor.
//   master: drives In_Valid, Johnson_In, Clear_Count; observes results.
//   slave : the monitor; drives Index_Out, One_Hot_Out, Code_Valid,
//           Locked, Step_Error, Error_Count.
// Handshake: Johnson_In and Clear_Count are sampled on the rising clock
// edge; Johnson_In only when In_Valid=1 (no back-pressure, the monitor
// accepts every valid sample). Clear_Count is honoured every cycle.
interface johnson_code_monitor_if #(
  parameter int N         = 4,
  parameter int ERR_CNT_W = 8
);
  localparam int IW = $clog2(2 * N);

  logic                 In_Valid;
  logic [N-1:0]         Johnson_In;
  logic                 Clear_Count;
  logic [IW-1:0]        Index_Out;
  logic [2*N-1:0]       One_Hot_Out;
  logic                 Code_Valid;
  logic                 Locked;
  logic                 Step_Error;
  logic [ERR_CNT_W-1:0] Error_Count;

  modport master (
    output In_Valid, Johnson_In, Clear_Count,
    input  Index_Out, One_Hot_Out, Code_Valid, Locked, Step_Error, Error_Count
  );

  modport slave (
    input  In_Valid, Johnson_In, Clear_Count,
    output Index_Out, One_Hot_Out, Code_Valid, Locked, Step_Error, Error_Count
  );
endinterface

// File: rtl/johnson_decode.sv
// Combinational Johnson word decoder.
//   word    : N-bit Johnson-coded input
//   legal   : word is a legal Johnson state
//   index   : decoded state index 0..2N-1 (meaningful only when legal)
//   one_hot : bit index set when legal, all zero otherwise
module johnson_decode
  import johnson_code_monitor_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = $clog2(2 * N)
) (
  input  logic [N-1:0]   word,
  output logic           legal,
  output logic [IW-1:0]  index,
  output logic [2*N-1:0] one_hot
);

  logic [MAX_W-1:0] word_ext;
  int               idx_full;

  always_comb begin
    word_ext         = '0;
    word_ext[N-1:0]  = word;
    legal            = johnson_is_legal(word_ext, N);
    idx_full         = johnson_to_index(word_ext, N);
    index            = idx_full[IW-1:0];
    one_hot          = '0;
    for (int i = 0; i < 2 * N; i++) begin
      one_hot[i] = legal && (idx_full == i);
    end
  end

endmodule

// File: rtl/johnson_code_monitor.sv
// Johnson code monitor: samples a Johnson-coded phase bus, decodes it to
// an index and one-hot phase, and checks that the bus advances by exactly
// one state per valid sample.
//   Clock, Reset : rising-edge clock, asynchronous active-high reset
//   bus (slave)  : In_Valid, Johnson_In, Clear_Count in;
//                  Index_Out, One_Hot_Out, Code_Valid, Locked,
//                  Step_Error, Error_Count out (all registered).
// FSM state is visible directly on Locked (HUNT=0, LOCKED=1).
module johnson_code_monitor
  import johnson_code_monitor_pkg::*;
#(
  parameter int N          = 4,
  parameter int LOCK_COUNT = 2,
  parameter int ERR_CNT_W  = 8
) (
  input logic                    Clock,
  input logic                    Reset,
  johnson_code_monitor_if.slave  bus
);

  localparam int             IW       = $clog2(2 * N);
  localparam logic [IW-1:0]  LAST_IDX = IW'(2 * N - 1);
  localparam logic [3:0]     LOCK_RUN = 4'(LOCK_COUNT);

  logic                 dec_legal;
  logic [IW-1:0]        dec_index;
  logic [2*N-1:0]       dec_one_hot;

  jcm_state_e           state_q, state_n;
  logic [3:0]           run_q, run_n;
  logic                 prev_valid_q, prev_valid_n;
  logic [IW-1:0]        index_q, index_n;
  logic [2*N-1:0]       one_hot_q, one_hot_n;
  logic                 code_valid_q, code_valid_n;
  logic                 step_err_q, step_err_n;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_n;

  logic                 err_inc;
  logic [IW-1:0]        exp_idx;
  logic                 advance;

  johnson_decode #(.N(N)) u_decode (
    .word    (bus.Johnson_In),
    .legal   (dec_legal),
    .index   (dec_index),
    .one_hot (dec_one_hot)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q      <= HUNT;
      run_q        <= '0;
      prev_valid_q <= 1'b0;
      index_q      <= '0;
      one_hot_q    <= '0;
      code_valid_q <= 1'b0;
      step_err_q   <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_n;
      run_q        <= run_n;
      prev_valid_q <= prev_valid_n;
      index_q      <= index_n;
      one_hot_q    <= one_hot_n;
      code_valid_q <= code_valid_n;
      step_err_q   <= step_err_n;
      err_cnt_q    <= err_cnt_n;
    end
  end

  always_comb begin
    state_n      = state_q;
    run_n        = run_q;
    prev_valid_n = prev_valid_q;
    index_n      = index_q;
    one_hot_n    = one_hot_q;
    code_valid_n = code_valid_q;
    step_err_n   = 1'b0;
    err_inc      = 1'b0;

    // index_q only ever updates on legal samples, so it doubles as the
    // previous legal index; prev_valid_q stops the first sample after
    // reset from counting as an advance from index 0.
    exp_idx = (index_q == LAST_IDX) ? '0 : index_q + IW'(1);
    advance = dec_legal && prev_valid_q && (dec_index == exp_idx);

    if (bus.In_Valid) begin
      code_valid_n = dec_legal;
      one_hot_n    = dec_one_hot;
      if (dec_legal) begin
        index_n      = dec_index;
        prev_valid_n = 1'b1;
      end

      case (state_q)
        HUNT: begin
          if (advance) begin
            if (run_q + 4'd1 == LOCK_RUN) begin
              state_n = LOCKED;
              run_n   = '0;
            end else begin
              run_n = run_q + 4'd1;
            end
          end else begin
            run_n = '0;
          end
        end
        LOCKED: begin
          if (!advance) begin
            step_err_n = 1'b1;
            err_inc    = 1'b1;
            state_n    = HUNT;
            run_n      = '0;
          end
        end
        default: begin
          state_n = HUNT;
          run_n   = '0;
        end
      endcase
    end

    // Clear wins over a same-cycle increment; the counter sticks at all-ones.
    err_cnt_n = err_cnt_q;
    if (bus.Clear_Count) begin
      err_cnt_n = '0;
    end else if (err_inc && (err_cnt_q != '1)) begin
      err_cnt_n = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  assign bus.Index_Out   = index_q;
  assign bus.One_Hot_Out = one_hot_q;
  assign bus.Code_Valid  = code_valid_q;
  assign bus.Locked      = (state_q == LOCKED);
  assign bus.Step_Error  = step_err_q;
  assign bus.Error_Count = err_cnt_q;

endmodule

// File: tb/tb_johnson_code_monitor.sv
module tb_johnson_code_monitor;

  localparam int N     = 4;
  localparam int SEQ   = 2 * N;
  localparam int LOCKC = 2;
  localparam int ECW   = 2;
  localparam int EMAX  = (1 << ECW) - 1;
  localparam int EXP_W = 3 + SEQ + 3 + ECW;

  logic Clock;
  logic Reset;

  johnson_code_monitor_if #(.N(N), .ERR_CNT_W(ECW)) bus ();

  johnson_code_monitor #(.N(N), .LOCK_COUNT(LOCKC), .ERR_CNT_W(ECW)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // ---------------- scoreboard state ----------------
  logic [EXP_W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  // Johnson table built from the sequence definition; legality and
  // decoding are done by lookup in this table.
  logic [N-1:0] jtab[SEQ];
  int           m_idx;
  logic         m_prev_valid;
  logic         m_locked;
  int           m_run;
  int           m_err;
  logic         m_cv;
  logic [SEQ-1:0] m_oh;
  logic         m_step;
  int           cur;

  function automatic int lookup(input logic [N-1:0] w);
    for (int k = 0; k < SEQ; k++) if (jtab[k] == w) return k;
    return -1;
  endfunction

  task automatic model_reset();
    m_idx = 0; m_prev_valid = 1'b0; m_locked = 1'b0; m_run = 0;
    m_err = 0; m_cv = 1'b0; m_oh = '0; m_step = 1'b0;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic [N-1:0] w, input logic clr);
    int   k;
    logic adv;
    @(negedge Clock);
    bus.In_Valid    = v;
    bus.Johnson_In  = w;
    bus.Clear_Count = clr;
    m_step = 1'b0;
    if (v) begin
      k   = lookup(w);
      adv = (k >= 0) && m_prev_valid && (k == (m_idx + 1) % SEQ);
      if (!m_locked) begin
        if (adv) m_run++; else m_run = 0;
        if (m_run == LOCKC) begin m_locked = 1'b1; m_run = 0; end
      end else if (!adv) begin
        m_step = 1'b1; m_locked = 1'b0; m_run = 0;
        if (m_err < EMAX) m_err++;
      end
      if (k >= 0) begin
        m_idx = k; m_prev_valid = 1'b1; m_cv = 1'b1;
        m_oh = SEQ'(1) << k;
      end else begin
        m_cv = 1'b0; m_oh = '0;
      end
    end
    if (clr) m_err = 0;
    exp_q.push_back({3'(m_idx), m_oh, m_cv, m_locked, m_step, ECW'(m_err)});
  endtask

  task automatic adv_n(input int n);
    for (int i = 0; i < n; i++) begin
      cur = (cur + 1) % SEQ;
      drive(1'b1, jtab[cur], 1'b0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_index"},  int'(bus.Index_Out),   0);
    check({tag, "_onehot"}, int'(bus.One_Hot_Out), 0);
    check({tag, "_cvalid"}, int'(bus.Code_Valid),  0);
    check({tag, "_locked"}, int'(bus.Locked),      0);
    check({tag, "_steperr"},int'(bus.Step_Error),  0);
    check({tag, "_errcnt"}, int'(bus.Error_Count), 0);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [EXP_W-1:0] e;
    forever begin
      @(posedge Clock);
      #1;
      if (!Reset && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("index",   int'(bus.Index_Out),   int'(e[EXP_W-1 -: 3]));
        check("onehot",  int'(bus.One_Hot_Out), int'(e[EXP_W-4 -: SEQ]));
        check("cvalid",  int'(bus.Code_Valid),  int'(e[ECW+2]));
        check("locked",  int'(bus.Locked),      int'(e[ECW+1]));
        check("steperr", int'(bus.Step_Error),  int'(e[ECW]));
        check("errcnt",  int'(bus.Error_Count), int'(e[ECW-1:0]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int r;
    logic [N-1:0] w;
    int k;

    for (int kk = 0; kk < SEQ; kk++) begin
      if (kk <= N) jtab[kk] = N'((1 << kk) - 1);
      else         jtab[kk] = N'(((1 << N) - 1) << (kk - N));
    end

    Reset = 1'b1;
    bus.In_Valid = 1'b0; bus.Johnson_In = '0; bus.Clear_Count = 1'b0;
    model_reset();
    repeat (3) @(posedge Clock);
    #1;
    check_all_zero("reset");
    @(negedge Clock);
    Reset = 1'b0;

    // Full sequence with wrap
    cur = 0;
    drive(1'b1, jtab[0], 1'b0);
    adv_n(11);

    // Illegal word while locked, then relock
    drive(1'b1, 4'b0101, 1'b0);
    adv_n(3);

    // Skip one state while locked
    cur = (cur + 2) % SEQ;
    drive(1'b1, jtab[cur], 1'b0);
    adv_n(3);

    // In_Valid low with a changing word; resume keeps lock
    for (int i = 0; i < 5; i++) drive(1'b0, N'($urandom_range(0, 15)), 1'b0);
    adv_n(2);

    // Hold (same index) while locked
    drive(1'b1, jtab[cur], 1'b0);
    adv_n(3);

    // Saturation: repeated violations with relock between
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'b0101, 1'b0);
      adv_n(3);
    end

    // Clear together with a violation
    drive(1'b1, 4'b1010, 1'b1);
    adv_n(3);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 65) begin
        cur = (cur + 1) % SEQ;
        drive(1'b1, jtab[cur], ($urandom_range(0, 19) == 0));
      end else if (r < 75) begin
        drive(1'b0, N'($urandom_range(0, 15)), ($urandom_range(0, 19) == 0));
      end else if (r < 85) begin
        cur = $urandom_range(0, SEQ - 1);
        drive(1'b1, jtab[cur], 1'b0);
      end else begin
        w = N'($urandom_range(0, 15));
        k = lookup(w);
        if (k >= 0) cur = k;
        drive(1'b1, w, 1'b0);
      end
    end

    // Relock, then asynchronous reset mid-lock
    adv_n(3);
    @(posedge Clock);
    #3;
    Reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    model_reset();
    @(negedge Clock);
    Reset = 1'b0;
    cur = $urandom_range(0, SEQ - 1);
    drive(1'b1, jtab[cur], 1'b0);
    adv_n(1);
    adv_n(2);

    @(posedge Clock);
    #2;
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
